// File: rtl/serial_rx_ctrl_if.sv
// rtl/serial_rx_ctrl_if.sv - serial receive front-end control/status bundle
interface serial_rx_ctrl_if;
    logic en;
    logic rx;
    logic shift_en;
    logic bit_out;
    logic busy;
    logic frame_valid;
    logic frame_err;

    modport master (
        output en,
        output rx,
        input  shift_en,
        input  bit_out,
        input  busy,
        input  frame_valid,
        input  frame_err
    );

    modport slave (
        input  en,
        input  rx,
        output shift_en,
        output bit_out,
        output busy,
        output frame_valid,
        output frame_err
    );
endinterface

// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - oversampling serial receiver front end driving a SIPO
module serial_rx_ctrl #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_rx_ctrl_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          rx_dly_q, rx_dly_d;
    logic          shift_en_q, shift_en_d;
    logic          bit_out_q, bit_out_d;
    logic          busy_q, busy_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;

    logic rx_s;
    logic rx_s_d;
    logic fall;
    logic tick;

    assign rx_s   = sync2_q;
    assign rx_s_d = rx_dly_q;
    assign fall   = rx_s_d & ~rx_s;
    // START waits half a bit to land mid start bit; later states step a full bit.
    assign tick   = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

    // Next-state, baud/bit counting and output pulse generation.
    always_comb begin
        sync1_d       = bus.rx;
        sync2_d       = sync1_q;
        rx_dly_d      = sync2_q;
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        bidx_d        = bidx_q;
        bit_out_d     = bit_out_q;
        shift_en_d    = 1'b0;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.en && fall) begin
                    state_d = S_START;
                    bidx_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    // A high line at mid start bit means a glitch: drop silently.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d      = '0;
                    bit_out_d  = rx_s;
                    shift_en_d = 1'b1;
                    if (bidx_q == BIDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bidx_d = bidx_q + BW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d         = '0;
                    frame_valid_d = rx_s;
                    frame_err_d   = ~rx_s;
                    // Leave at mid stop bit so a following start edge is not missed.
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, synchronizer and registered outputs; line flops idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bidx_q        <= '0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_dly_q      <= 1'b1;
            shift_en_q    <= 1'b0;
            bit_out_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bidx_q        <= bidx_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_dly_q      <= rx_dly_d;
            shift_en_q    <= shift_en_d;
            bit_out_q     <= bit_out_d;
            busy_q        <= busy_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.shift_en    = shift_en_q;
    assign bus.bit_out     = bit_out_q;
    assign bus.busy        = busy_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Front-end controller for the serial receive path. Oversamples an asynchronous serial line, detects and validates start bits, and centre-samples each data bit. Drives the shift_en/bit_in inputs of the downstream SIPO register one pulse per bit, so that after WIDTH pulses the SIPO holds the frame. Checks the stop bit and flags each frame as good or bad.

Parameters:
WIDTH, 8, data bits per frame; must equal the downstream SIPO WIDTH; legal range 2..32.
CLKS_PER_BIT, 16, clk cycles per serial bit period; must be even and >= 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  receive enable; when low, the block holds in IDLE.
rx  input  1  asynchronous serial line, idle high; frame order is start(0), WIDTH data bits MSB first, stop(1).
shift_en  output  1  one-cycle pulse per sampled data bit; connects to SIPO shift_en.
bit_out  output  1  sampled data bit; valid while shift_en=1; connects to SIPO bit_in.
busy  output  1  high in START, DATA and STOP states.
frame_valid  output  1  one-cycle pulse: stop bit sampled 1; SIPO contents are complete.
frame_err  output  1  one-cycle pulse: stop bit sampled 0 (framing error).

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters=0, synchronizer flops=1, and all outputs 0 (shift_en, bit_out, busy, frame_valid, frame_err).
- rx passes through a 2-flop synchronizer producing rx_s. A third flop holds rx_s_d for edge detection. All decisions use rx_s.
- Baud counter cnt:
  - Width is $clog2(CLKS_PER_BIT).
  - Cleared to 0 on every state entry.
  - Counts up each cycle.
  - A "sample tick" occurs when cnt == LIMIT-1, and cnt then returns to 0.
  - LIMIT = CLKS_PER_BIT/2 in START, and CLKS_PER_BIT in DATA and STOP.
- Bit index bidx counts 0..WIDTH-1 in DATA and is cleared on entry to START.
- FSM:
  - IDLE: if en=1 and a falling edge is seen (rx_s_d=1, rx_s=0), go to START. Otherwise stay.
  - START, on sample tick (mid start bit): if rx_s=0, go to DATA. If rx_s=1 (glitch or false start), go to IDLE with no outputs pulsed.
  - DATA, on sample tick: register bit_out <= rx_s and assert shift_en for exactly the next cycle. If bidx == WIDTH-1, go to STOP; else bidx++.
  - STOP, on sample tick: rx_s=1 pulses frame_valid for 1 cycle; rx_s=0 pulses frame_err for 1 cycle. Either way, go to IDLE.
- Pulse rules: shift_en, frame_valid and frame_err are registered outputs, high for exactly 1 cycle. They are never asserted together. frame_valid/frame_err fire at most once per frame, and only after exactly WIDTH shift_en pulses.
- bit_out holds its last value between pulses. Only its value while shift_en=1 is meaningful.
- Timing: from the rx falling edge at the pin, the first shift_en occurs 2 (sync) + 1 (edge) + CLKS_PER_BIT/2 + CLKS_PER_BIT cycles later, ±1. Data samples land mid-bit.
- Stop-bit handling after a framing error: returns to IDLE immediately. Because rx stays low, no falling edge occurs, so no new start is accepted until rx goes high and then falls again.
- Back-to-back frames: a start edge arriving in the first cycle after returning to IDLE is detected. There is no dead time beyond the remaining half stop bit.
- en deasserted mid-frame: the current frame completes normally. en is checked only in IDLE.
- Reset mid-frame: immediate return to reset state with no trailing pulses. The SIPO is reset by the same rst_n.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=16, send 0xA5 with a good stop bit. Expect 8 shift_en pulses spaced 16 cycles apart, bit_out sequence 1,0,1,0,0,1,0,1, one frame_valid 16 cycles after the last shift_en, and the attached SIPO data_out=0xA5. busy is high from START entry through the STOP tick.
2. rx low for 5 cycles, then high (glitch shorter than half a bit). Expect START rejected, return to IDLE, zero shift_en, no frame_valid or frame_err.
3. Send 0x3C with stop bit = 0. Expect 8 shift_en pulses, frame_err=1 for one cycle, frame_valid never high. Then hold rx low for 40 cycles: expect no new START. Then rx high, then send 0x81: expect frame_valid and SIPO=0x81.
4. Send 0xFF and 0x00 back-to-back with a single stop bit between them. Expect 16 shift_en pulses total, two frame_valid pulses, and SIPO values 0xFF then 0x00.
5. Assert rst_n low after the 4th shift_en of a frame. Expect all outputs 0 immediately. After release with rx idle high, expect no pulses until a new start bit; a new frame 0x5A is then received correctly.
6. en=0 while sending 0x12. Expect no activity and busy=0. Then en=1 and send 0x34: expect frame_valid and SIPO=0x34.
